// File: rtl/rv32i_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_ctrl_pkg
// Description : Shared definitions for the RV32I multi-cycle control unit.
//               Holds the opcode constants, ALU operation codes, write-back
//               source selects, the FSM state type and the control-word struct.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_ctrl_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_L     = 7'b0000011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_S     = 7'b0100011;
    localparam logic [6:0] c_OP_B     = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    // ALU operation codes: {funct7[5], funct3}
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;

    // Register-file write-back source selects
    localparam logic [2:0] c_RFWD_ALU   = 3'd0;
    localparam logic [2:0] c_RFWD_LOAD  = 3'd1;
    localparam logic [2:0] c_RFWD_IMM   = 3'd2;
    localparam logic [2:0] c_RFWD_AUIPC = 3'd3;
    localparam logic [2:0] c_RFWD_PC4   = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Decoded control word. reg_we here means "this instruction writes rd";
    // the FSM turns it into the actual one-cycle strobe.
    typedef struct packed {
        logic       reg_we;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] rfwd_sel;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] l_mode;
        logic [2:0] s_mode;
    } ctrl_word_t;

endpackage : rv32i_ctrl_pkg
`default_nettype wire

// File: rtl/rv32i_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_ctrl_decoder
// Description : Purely combinational RV32I instruction decoder. Maps the
//               instruction word to a control word plus load/store flags.
// Ports       : instr_code [31:0] in  - instruction word
//               ctrl                  out - decoded control word
//               is_load               out - instruction is a load
//               is_store              out - instruction is a store
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_ctrl_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [31:0] instr_code,
    output ctrl_word_t  ctrl,
    output logic        is_load,
    output logic        is_store
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic       w_unused;

    assign w_opcode   = instr_code[6:0];
    assign w_funct3   = instr_code[14:12];
    assign w_funct7_5 = instr_code[30];
    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused   = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

    always_comb begin
        ctrl     = '0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                ctrl.reg_we   = 1'b1;
                ctrl.alu_ctrl = {w_funct7_5, w_funct3};
            end
            c_OP_I: begin
                ctrl.reg_we   = 1'b1;
                ctrl.alu_src  = 1'b1;
                // Only shift-right uses bit 30 (SRLI/SRAI); for the rest it
                // is an immediate bit and must not leak into the ALU op.
                ctrl.alu_ctrl = (w_funct3 == 3'b101) ? {w_funct7_5, w_funct3}
                                                     : {1'b0, w_funct3};
            end
            c_OP_L: begin
                ctrl.reg_we   = 1'b1;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = c_ALU_ADD;
                ctrl.rfwd_sel = c_RFWD_LOAD;
                ctrl.l_mode   = w_funct3;
                is_load       = 1'b1;
            end
            c_OP_S: begin
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = c_ALU_ADD;
                ctrl.s_mode   = w_funct3;
                is_store      = 1'b1;
            end
            c_OP_B: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = {1'b0, w_funct3};
            end
            c_OP_LUI: begin
                ctrl.reg_we   = 1'b1;
                ctrl.rfwd_sel = c_RFWD_IMM;
            end
            c_OP_AUIPC: begin
                ctrl.reg_we   = 1'b1;
                ctrl.alu_ctrl = c_ALU_ADD;
                ctrl.rfwd_sel = c_RFWD_AUIPC;
            end
            c_OP_JAL: begin
                ctrl.reg_we   = 1'b1;
                ctrl.jal      = 1'b1;
                ctrl.alu_ctrl = c_ALU_ADD;
                ctrl.rfwd_sel = c_RFWD_PC4;
            end
            c_OP_JALR: begin
                ctrl.reg_we   = 1'b1;
                ctrl.jalr     = 1'b1;
                ctrl.alu_ctrl = c_ALU_ADD;
                ctrl.rfwd_sel = c_RFWD_PC4;
            end
            default: ; // unknown opcode: all-zero word behaves as a NOP
        endcase
    end

endmodule : rv32i_ctrl_decoder
`default_nettype wire

// File: rtl/rv32i_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_mc_control_unit
// Description : Multi-cycle control FSM (FETCH/DECODE/EXE/MEM/WB) for the
//               RV32I datapath. The control word is registered on entry to EXE
//               and held to the final state; strobes fire in the final state.
// Config      : BUS_READY_EN - adds busReady and MEM wait states.
// Ports       : clk, reset (sync, active-high), instrCode[31:0],
//               busReady (BUS_READY_EN only), regFileWe, aluControl[3:0],
//               aluSrcMuxSel, RFWDSrcMuxSel[2:0], branch, jal, jalr,
//               L_mode[2:0], S_mode[2:0], PC_En, busWe, busRe
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mc_control_unit
    import rv32i_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
`ifdef BUS_READY_EN
    input  logic        busReady,
`endif
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic [2:0]  L_mode,
    output logic [2:0]  S_mode,
    output logic        PC_En,
    output logic        busWe,
    output logic        busRe
);

    ctrl_word_t w_ctrl;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_mem_done;

    state_t     r_state;
    ctrl_word_t r_ctrl;      // reg_we bit doubles as the registered strobe
    logic       r_pc_en;
    logic       r_bus_we;
    logic       r_bus_re;

    rv32i_ctrl_decoder u_decoder (
        .instr_code (instrCode),
        .ctrl       (w_ctrl),
        .is_load    (w_is_load),
        .is_store   (w_is_store)
    );

`ifdef BUS_READY_EN
    assign w_mem_done = busReady;
    // A store retires in the very MEM cycle that sees busReady, so its PC
    // load cannot come from a flop set a cycle earlier.
    assign PC_En = r_pc_en | ((r_state == ST_MEM) & r_bus_we & busReady);
`else
    assign w_mem_done = 1'b1;
    assign PC_En = r_pc_en;
`endif

    assign regFileWe     = r_ctrl.reg_we;
    assign aluControl    = r_ctrl.alu_ctrl;
    assign aluSrcMuxSel  = r_ctrl.alu_src;
    assign RFWDSrcMuxSel = r_ctrl.rfwd_sel;
    assign branch        = r_ctrl.branch;
    assign jal           = r_ctrl.jal;
    assign jalr          = r_ctrl.jalr;
    assign L_mode        = r_ctrl.l_mode;
    assign S_mode        = r_ctrl.s_mode;
    assign busWe         = r_bus_we;
    assign busRe         = r_bus_re;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_ctrl   <= '0;
            r_pc_en  <= 1'b0;
            r_bus_we <= 1'b0;
            r_bus_re <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // Present the control word for EXE; the write strobe
                    // stays low until the final state.
                    r_state       <= ST_EXE;
                    r_ctrl        <= w_ctrl;
                    r_ctrl.reg_we <= 1'b0;
                end
                ST_EXE: begin
                    if (w_is_load || w_is_store) begin
                        r_state  <= ST_MEM;
                        r_bus_re <= w_is_load;
                        r_bus_we <= w_is_store;
`ifdef BUS_READY_EN
                        r_pc_en  <= 1'b0;
`else
                        r_pc_en  <= w_is_store;
`endif
                    end else begin
                        r_state       <= ST_WB;
                        r_ctrl.reg_we <= w_ctrl.reg_we;
                        r_pc_en       <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (w_mem_done) begin
                        if (w_is_load) begin
                            r_state       <= ST_WB;
                            r_bus_re      <= 1'b0;
                            r_ctrl.reg_we <= w_ctrl.reg_we;
                            r_pc_en       <= 1'b1;
                        end else begin
                            r_state  <= ST_FETCH;
                            r_ctrl   <= '0;
                            r_pc_en  <= 1'b0;
                            r_bus_we <= 1'b0;
                            r_bus_re <= 1'b0;
                        end
                    end
                end
                ST_WB: begin
                    r_state  <= ST_FETCH;
                    r_ctrl   <= '0;
                    r_pc_en  <= 1'b0;
                    r_bus_we <= 1'b0;
                    r_bus_re <= 1'b0;
                end
                default: begin
                    r_state  <= ST_FETCH;
                    r_ctrl   <= '0;
                    r_pc_en  <= 1'b0;
                    r_bus_we <= 1'b0;
                    r_bus_re <= 1'b0;
                end
            endcase
        end
    end

endmodule : rv32i_mc_control_unit
`default_nettype wire
